// File: rtl/logic_op_arbiter.sv
// Round-robin arbitrated bitwise logic unit shared by NREQ requesters.
// Optional LOGIC_OP_ARBITER_OPCNT_EN adds a saturating completed-operation counter (op_count).
module logic_op_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [3*NREQ-1:0]       op,
  input  logic [WIDTH*NREQ-1:0]   opa,
  input  logic [WIDTH*NREQ-1:0]   opb,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    res_valid,
  output logic [IDW-1:0]          res_id,
  output logic [WIDTH-1:0]        res_data,
  output logic                    res_err
`ifdef LOGIC_OP_ARBITER_OPCNT_EN
  ,
  output logic [15:0]             op_count
`endif
);

  localparam int unsigned CNTW = 16;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   rr;
  logic [IDW-1:0]   id_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [IDW-1:0]   win_c;
  logic [IDW-1:0]   rr_nxt_c;
  logic             any_req_c;
  logic [2:0]       sel_op_c;
  logic [WIDTH-1:0] sel_a_c;
  logic [WIDTH-1:0] sel_b_c;

  // Round-robin pick: rotate requests so the rr pointer sits at bit 0, take the lowest set bit.
  always_comb begin
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int unsigned       off;
    int unsigned       w;
    any_req_c = |req;
    dbl       = {req, req} >> rr;
    rot       = dbl[NREQ-1:0];
    off       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = 32'(k);
    end
    w = 32'(rr) + off;
    if (w >= NREQ) w = w - NREQ;
    win_c    = IDW'(w);
    rr_nxt_c = (w + 1 >= NREQ) ? '0 : IDW'(w + 1);
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_op_c = '0;
    sel_a_c  = '0;
    sel_b_c  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_c == IDW'(i)) begin
        sel_op_c = op[3*i +: 3];
        sel_a_c  = opa[WIDTH*i +: WIDTH];
        sel_b_c  = opb[WIDTH*i +: WIDTH];
      end
    end
  end

  function automatic logic [WIDTH:0] logic_op(input logic [2:0] o,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (o)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, a ^ b};
      3'd3:    return {1'b0, ~(a & b)};
      3'd4:    return {1'b0, ~(a | b)};
      3'd5:    return {1'b0, ~(a ^ b)};
      3'd6:    return {1'b0, ~a};
      default: return {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  // Sequencer: arbitrate in IDLE/RESP, grant+execute in EXEC, present result in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= '0;
      id_q      <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      gnt       <= '0;
      res_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (any_req_c) begin
            state <= EXEC;
            busy  <= 1'b1;
            gnt   <= NREQ'(1) << win_c;
            rr    <= rr_nxt_c;
            id_q  <= win_c;
            op_q  <= sel_op_c;
            a_q   <= sel_a_c;
            b_q   <= sel_b_c;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        EXEC: begin
          state                <= RESP;
          busy                 <= 1'b1;
          res_valid            <= 1'b1;
          res_id               <= id_q;
          {res_err, res_data}  <= logic_op(op_q, a_q, b_q);
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOGIC_OP_ARBITER_OPCNT_EN
  // Counts every presented result, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (res_valid && (op_count != {CNTW{1'b1}})) begin
      op_count <= op_count + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Randomized and directed bench for logic_op_arbiter against a transaction-level reference model.
// Define LOGIC_OP_ARBITER_OPCNT_EN to also check op_count.
module tb_logic_op_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [3*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] opa;
  logic [WIDTH*NREQ-1:0] opb;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [WIDTH-1:0]      res_data;
  logic                  res_err;
`ifdef LOGIC_OP_ARBITER_OPCNT_EN
  logic [15:0]           op_count;
`endif

  logic_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .opa(opa), .opb(opb),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id),
    .res_data(res_data), .res_err(res_err)
`ifdef LOGIC_OP_ARBITER_OPCNT_EN
    , .op_count(op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 = free, 2 = operation granted this cycle, 1 = result on the bus.
  int              phase;
  int              rr_m;
  int              cur_w;
  logic [2:0]      cur_op;
  logic [7:0]      cur_a, cur_b;
  logic [NREQ-1:0] m_gnt;
  logic            m_rv;
  int              m_id;
  logic [7:0]      m_data;
  logic            m_err;
  int              m_cnt;
  logic [10:0]     res_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, a ^ b};
      3'd3: return {1'b0, ~(a & b)};
      3'd4: return {1'b0, ~(a | b)};
      3'd5: return {1'b0, ~(a ^ b)};
      3'd6: return {1'b0, ~a};
      default: return 9'h100;
    endcase
  endfunction

  task automatic model_reset();
    phase = 0; rr_m = 0; cur_w = 0; cur_op = 0; cur_a = 0; cur_b = 0;
    m_gnt = '0; m_rv = 0; m_id = 0; m_data = 0; m_err = 0; m_cnt = 0;
  endtask

  // Advance the model by one clock edge using the request lines as they stood at that edge.
  task automatic model_step();
    logic [8:0] r;
    bit found;
    if (m_rv && m_cnt < 65535) m_cnt++;
    m_rv  = 0;
    m_gnt = '0;
    if (phase == 2) begin
      r = ref_op(cur_op, cur_a, cur_b);
      m_err = r[8]; m_data = r[7:0]; m_id = cur_w; m_rv = 1; phase = 1;
    end else begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (rr_m + k) % NREQ;
        if (!found && req[i]) begin
          found = 1; cur_w = i;
        end
      end
      if (found) begin
        cur_op = op[3*cur_w +: 3];
        cur_a  = opa[8*cur_w +: 8];
        cur_b  = opb[8*cur_w +: 8];
        rr_m   = (cur_w + 1) % NREQ;
        m_gnt[cur_w] = 1'b1;
        phase  = 2;
      end else begin
        phase = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("busy", 32'(busy), 32'(phase != 0));
    chk("res_valid", 32'(res_valid), 32'(m_rv));
    chk("res_id", 32'(res_id), 32'(m_id));
    chk("res_data", 32'(res_data), 32'(m_data));
    chk("res_err", 32'(res_err), 32'(m_err));
`ifdef LOGIC_OP_ARBITER_OPCNT_EN
    chk("op_count", 32'(op_count), 32'(m_cnt));
`endif
    if (res_valid) res_log.push_back({res_err, res_id, res_data});
  endtask

  task automatic raise(input int i, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    op[3*i +: 3] = o;
    opa[8*i +: 8] = a;
    opb[8*i +: 8] = b;
    req[i] = 1'b1;
  endtask

  // One clock: model follows the edge, requesters react (drop after grant, maybe raise new work).
  task automatic step(input bit rnd);
    logic [NREQ-1:0] prev_gnt;
    prev_gnt = m_gnt;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (prev_gnt[i]) begin
        req[i] = 1'b0;
        opa[8*i +: 8] = 8'($urandom);
        opb[8*i +: 8] = 8'($urandom);
        op[3*i +: 3]  = 3'($urandom);
      end else if (rnd) begin
        if (!req[i] && $urandom_range(0, 2) == 0)
          raise(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        else if (req[i] && $urandom_range(0, 31) == 0)
          req[i] = 1'b0;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic steps(input int n, input bit rnd);
    for (int k = 0; k < n; k++) step(rnd);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; op = '0; opa = '0; opb = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Reset while an operation is executing.
    raise(1, 3'd0, 8'hF0, 8'h3C);
    step(0);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    req = '0;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rv", 32'(res_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    steps(3, 0);

    // All four requesting, pointer restarted at 0.
    res_log.delete();
    raise(0, 3'd0, 8'hCC, 8'hAA);
    raise(1, 3'd1, 8'hCC, 8'hAA);
    raise(2, 3'd4, 8'hCC, 8'hAA);
    raise(3, 3'd6, 8'hCC, 8'hAA);
    steps(10, 0);
    chk("all4_n", 32'(res_log.size()), 32'd4);
    if (res_log.size() == 4) begin
      chk("all4_r0", 32'(res_log[0]), 32'({1'b0, 2'd0, 8'h88}));
      chk("all4_r1", 32'(res_log[1]), 32'({1'b0, 2'd1, 8'hEE}));
      chk("all4_r2", 32'(res_log[2]), 32'({1'b0, 2'd2, 8'h11}));
      chk("all4_r3", 32'(res_log[3]), 32'({1'b0, 2'd3, 8'h33}));
    end

    // Wrap-around after the grant to 3.
    res_log.delete();
    raise(0, 3'd2, 8'h0F, 8'hFF);
    raise(3, 3'd5, 8'h0F, 8'hFF);
    steps(8, 0);
    chk("wrap_n", 32'(res_log.size()), 32'd2);
    if (res_log.size() == 2) begin
      chk("wrap_first", 32'(res_log[0]), 32'({1'b0, 2'd0, 8'hF0}));
      chk("wrap_second", 32'(res_log[1]), 32'({1'b0, 2'd3, 8'h0F}));
    end

    // Single XOR request.
    res_log.delete();
    raise(2, 3'd2, 8'hA5, 8'h0F);
    steps(5, 0);
    chk("single_n", 32'(res_log.size()), 32'd1);
    if (res_log.size() == 1) chk("single_res", 32'(res_log[0]), 32'({1'b0, 2'd2, 8'hAA}));

    // Illegal opcode.
    res_log.delete();
    raise(0, 3'd7, 8'hFF, 8'hFF);
    steps(5, 0);
    chk("illegal_n", 32'(res_log.size()), 32'd1);
    if (res_log.size() == 1) chk("illegal_res", 32'(res_log[0]), 32'({1'b1, 2'd0, 8'h00}));

    // Random traffic, then drain.
    steps(3000, 1);
    req = '0;
    steps(6, 0);
    chk("drained_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shared logic-operation unit arbitrated among NREQ requesters.
- Each requester presents two WIDTH-bit operands and a 3-bit opcode selecting AND/OR/XOR/NAND/NOR/XNOR/NOT.
- A round-robin arbiter grants one requester at a time. A small FSM sequences operand capture, execution and result return, tagged with the requester id.
- Sits between multiple client blocks and the bitwise gate datapath, so a single gate bank serves all clients.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- IDW, 2, requester id width; must satisfy 2**IDW >= NREQ

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NREQ  request per requester, held high until own gnt seen
- op  input  3*NREQ  opcode, requester i at bits [3i+2:3i]
- opa  input  WIDTH*NREQ  operand a, requester i at [WIDTH*i+WIDTH-1:WIDTH*i]
- opb  input  WIDTH*NREQ  operand b, same packing
- gnt  output  NREQ  one-cycle grant pulse, one-hot
- busy  output  1  high in EXEC and RESP
- res_valid  output  1  one-cycle result strobe
- res_id  output  IDW  requester index owning the result
- res_data  output  WIDTH  result
- res_err  output  1  illegal opcode flag, qualified by res_valid

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, rr pointer=0, gnt=0, busy=0, res_valid=0, res_id=0, res_data=0, res_err=0. Any in-flight operation is dropped; no res_valid is emitted for it.
- Opcodes (bitwise, registered):
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR: a op b
  - 6 NOT: ~a, b ignored
  - 7 illegal: res_data=0, res_err=1
- Arbitration:
  - Round-robin search starts at rr pointer and wraps NREQ-1 -> 0.
  - Winner w sets rr = (w+1) mod NREQ.
  - Runs only on edges where state is IDLE or RESP.
- FSM:
  - IDLE: if |req at the edge, latch op/opa/opb/id of w, go to EXEC. Else stay.
  - EXEC: gnt[w]=1 for this cycle only, busy=1. At the edge, register result/err/id, go to RESP.
  - RESP: res_valid=1 for one cycle, busy=1. At the edge, if |req, arbitrate and go to EXEC (back-to-back); else go to IDLE.
- Latency:
  - req sampled at edge E0 -> gnt high the cycle after E0 -> res_valid high the second cycle after E0.
  - Throughput: one operation per 2 cycles under continuous load.
- Requester contract: drop req on the edge ending the gnt cycle. Operands and opcode may change after gnt.
- Requests raised during EXEC are not sampled until the RESP edge.
- res_data, res_id and res_err hold their last values when res_valid=0.
- Simultaneous requests: resolved purely by the rr pointer; no starvation. Each requester waits at most NREQ-1 other grants.
- req deasserted before grant: request is simply never granted; no error.

Optional Feature:
- Macro: LOGIC_OP_ARBITER_OPCNT_EN.
- When defined:
  - Adds output op_count [15:0], reset to 0.
  - Increments on every res_valid, including illegal opcodes.
  - Saturates at 16'hFFFF.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-op: req[1]=1, op=0, a=8'hF0, b=8'h3C; assert rst_n=0 during EXEC -> all outputs 0 immediately, no res_valid after release, rr=0.
- Single request: req[2]=1, op=2 (XOR), a=8'hA5, b=8'h0F -> gnt=4'b0100 one cycle after sample; next cycle res_valid=1, res_id=2, res_data=8'hAA, res_err=0.
- All four req high from reset with opcodes 0,1,4,6 and a=8'hCC, b=8'hAA:
  - Grants in order 0,1,2,3 on consecutive 2-cycle slots.
  - Results 8'h88, 8'hEE, 8'h11, 8'h33.
- Wrap-around: after the grant to 3, req[0] and req[3] both high -> requester 0 granted first, then 3.
- Illegal opcode: req[0]=1, op=7 -> res_valid=1, res_err=1, res_data=8'h00.
- With LOGIC_OP_ARBITER_OPCNT_EN defined:
  - 5 completed ops -> op_count=5.
  - Force counter to 16'hFFFE, then run 3 ops -> op_count=16'hFFFF.
